// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Holds the FSM state, default widths and the per-stage control bundle.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_NUM_W = 5;
    localparam int CNT_W     = 32;
    localparam int WAIT_W    = 8;

    typedef enum logic {
        ST_RUN,
        ST_MEM_WAIT
    } hz_state_e;

    typedef struct packed {
        logic pc_wr_en;
        logic pc_sel_branch;
        logic ifid_wr_en;
        logic ifid_flush;
        logic idex_wr_en;
        logic idex_flush;
        logic exmem_wr_en;
        logic exmem_flush;
        logic memwb_bubble;
    } ctrl_en_t;

    // Free-running pipeline: every register loads, nothing is squashed.
    function automatic ctrl_en_t ctrl_default();
        ctrl_en_t c;
        c.pc_wr_en      = 1'b1;
        c.pc_sel_branch = 1'b0;
        c.ifid_wr_en    = 1'b1;
        c.ifid_flush    = 1'b0;
        c.idex_wr_en    = 1'b1;
        c.idex_flush    = 1'b0;
        c.exmem_wr_en   = 1'b1;
        c.exmem_flush   = 1'b0;
        c.memwb_bubble  = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with increment enable.
// Sticks at all-ones instead of wrapping.
module hazard_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // Count enabled events, holding at the maximum value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Arbitrates memory waits, taken branches and load-use hazards.
module pipeline_hazard_ctrl #(
    parameter int REG_NUM_W   = pipeline_hazard_ctrl_pkg::REG_NUM_W,
    parameter int CNT_W       = pipeline_hazard_ctrl_pkg::CNT_W,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_NUM_W-1:0] id_rs,
    input  logic [REG_NUM_W-1:0] id_rt,
    input  logic                 id_uses_rs,
    input  logic                 id_uses_rt,
    input  logic                 ex_mem_read,
    input  logic [REG_NUM_W-1:0] ex_rf_wr_num,
    input  logic                 mem_branch,
    input  logic                 mem_is_equal,
    input  logic                 mem_mem_read,
    input  logic                 mem_mem_write,
    input  logic                 dmem_ack,
    output logic                 dmem_req,
    output logic                 pc_wr_en,
    output logic                 pc_sel_branch,
    output logic                 ifid_wr_en,
    output logic                 ifid_flush,
    output logic                 idex_wr_en,
    output logic                 idex_flush,
    output logic                 exmem_wr_en,
    output logic                 exmem_flush,
    output logic                 memwb_bubble,
    output logic                 mem_timeout_err,
    output logic [CNT_W-1:0]     stall_cycles,
    output logic [CNT_W-1:0]     branch_flushes
);

    import pipeline_hazard_ctrl_pkg::*;

    localparam logic [WAIT_W-1:0] LP_TIMEOUT = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] LP_TO_M1   = WAIT_W'(MEM_TIMEOUT - 1);

    hz_state_e         r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_err;

    logic     w_mem_acc;
    logic     w_hazard;
    logic     w_freeze;
    logic     w_taken;
    logic     w_load_use;
    logic     w_dmem_req;
    ctrl_en_t w_ctrl;

    assign w_mem_acc = mem_mem_read | mem_mem_write;

    // Register 0 is hardwired, so a load targeting it never blocks ID.
    assign w_hazard = ex_mem_read
                    && (ex_rf_wr_num != '0)
                    && ((id_uses_rs && (id_rs == ex_rf_wr_num))
                     || (id_uses_rt && (id_rt == ex_rf_wr_num)));

    // Resolve the highest-priority event into per-stage enables/flushes.
    always_comb begin
        w_ctrl     = ctrl_default();
        w_dmem_req = 1'b0;
        w_freeze   = 1'b0;
        w_taken    = 1'b0;
        w_load_use = 1'b0;
        if (rst) begin
            w_dmem_req = (r_state == ST_MEM_WAIT) || w_mem_acc;
            w_freeze   = w_dmem_req && !dmem_ack;
            w_taken    = !w_freeze && mem_branch && mem_is_equal;
            w_load_use = !w_freeze && !w_taken && w_hazard;
            unique case (1'b1)
                w_freeze: begin
                    w_ctrl.pc_wr_en     = 1'b0;
                    w_ctrl.ifid_wr_en   = 1'b0;
                    w_ctrl.idex_wr_en   = 1'b0;
                    w_ctrl.exmem_wr_en  = 1'b0;
                    w_ctrl.memwb_bubble = 1'b1;
                end
                w_taken: begin
                    w_ctrl.pc_sel_branch = 1'b1;
                    w_ctrl.ifid_flush    = 1'b1;
                    w_ctrl.idex_flush    = 1'b1;
                    w_ctrl.exmem_flush   = 1'b1;
                end
                w_load_use: begin
                    w_ctrl.pc_wr_en   = 1'b0;
                    w_ctrl.ifid_wr_en = 1'b0;
                    w_ctrl.idex_flush = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Memory-wait FSM with saturating wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            unique case (r_state)
                ST_RUN: begin
                    r_wait_cnt <= '0;
                    if (w_mem_acc && !dmem_ack) begin
                        r_state <= ST_MEM_WAIT;
                    end
                end
                ST_MEM_WAIT: begin
                    if (dmem_ack) begin
                        r_state    <= ST_RUN;
                        r_wait_cnt <= '0;
                    end else begin
                        if (r_wait_cnt != LP_TIMEOUT) begin
                            r_wait_cnt <= r_wait_cnt + 1'b1;
                        end
                        if (r_wait_cnt >= LP_TO_M1) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    hazard_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (!w_ctrl.pc_wr_en),
        .o_count (stall_cycles)
    );

    hazard_sat_counter #(.W(CNT_W)) u_branch_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_taken),
        .o_count (branch_flushes)
    );

    assign dmem_req        = w_dmem_req;
    assign pc_wr_en        = w_ctrl.pc_wr_en;
    assign pc_sel_branch   = w_ctrl.pc_sel_branch;
    assign ifid_wr_en      = w_ctrl.ifid_wr_en;
    assign ifid_flush      = w_ctrl.ifid_flush;
    assign idex_wr_en      = w_ctrl.idex_wr_en;
    assign idex_flush      = w_ctrl.idex_flush;
    assign exmem_wr_en     = w_ctrl.exmem_wr_en;
    assign exmem_flush     = w_ctrl.exmem_flush;
    assign memwb_bubble    = w_ctrl.memwb_bubble;
    assign mem_timeout_err = r_err;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl.
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int TO = 4;
    localparam longint CMAX = 64'hFFFF_FFFF;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic       ex_mem_read;
    logic [4:0] ex_rf_wr_num;
    logic       mem_branch;
    logic       mem_is_equal;
    logic       mem_mem_read;
    logic       mem_mem_write;
    logic       dmem_ack;
    logic       dmem_req;
    logic       pc_wr_en;
    logic       pc_sel_branch;
    logic       ifid_wr_en;
    logic       ifid_flush;
    logic       idex_wr_en;
    logic       idex_flush;
    logic       exmem_wr_en;
    logic       exmem_flush;
    logic       memwb_bubble;
    logic       mem_timeout_err;
    logic [31:0] stall_cycles;
    logic [31:0] branch_flushes;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    bit     m_waiting;
    int     m_wcnt;
    bit     m_err;
    longint m_stall;
    longint m_brf;

    // Expected combinational outputs for the current cycle
    bit e_req, e_frz, e_tk, e_lu;

    pipeline_hazard_ctrl #(
        .REG_NUM_W   (5),
        .CNT_W       (32),
        .MEM_TIMEOUT (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .ex_mem_read     (ex_mem_read),
        .ex_rf_wr_num    (ex_rf_wr_num),
        .mem_branch      (mem_branch),
        .mem_is_equal    (mem_is_equal),
        .mem_mem_read    (mem_mem_read),
        .mem_mem_write   (mem_mem_write),
        .dmem_ack        (dmem_ack),
        .dmem_req        (dmem_req),
        .pc_wr_en        (pc_wr_en),
        .pc_sel_branch   (pc_sel_branch),
        .ifid_wr_en      (ifid_wr_en),
        .ifid_flush      (ifid_flush),
        .idex_wr_en      (idex_wr_en),
        .idex_flush      (idex_flush),
        .exmem_wr_en     (exmem_wr_en),
        .exmem_flush     (exmem_flush),
        .memwb_bubble    (memwb_bubble),
        .mem_timeout_err (mem_timeout_err),
        .stall_cycles    (stall_cycles),
        .branch_flushes  (branch_flushes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle, DUT outputs vs model
    always @(negedge clk) begin
        bit acc, hit;
        if (!rst) begin
            m_waiting = 0;
            m_wcnt    = 0;
            m_err     = 0;
            m_stall   = 0;
            m_brf     = 0;
        end
        acc = mem_mem_read || mem_mem_write;
        hit = ex_mem_read && ex_rf_wr_num != 0 &&
              ((id_uses_rs && id_rs == ex_rf_wr_num) ||
               (id_uses_rt && id_rt == ex_rf_wr_num));
        e_req = rst && (m_waiting || acc);
        e_frz = e_req && !dmem_ack;
        e_tk  = rst && !e_frz && mem_branch && mem_is_equal;
        e_lu  = rst && !e_frz && !e_tk && hit;
        chk("dmem_req",       dmem_req,      e_req);
        chk("pc_wr_en",       pc_wr_en,      !(e_frz || e_lu));
        chk("pc_sel_branch",  pc_sel_branch, e_tk);
        chk("ifid_wr_en",     ifid_wr_en,    !(e_frz || e_lu));
        chk("ifid_flush",     ifid_flush,    e_tk);
        chk("idex_wr_en",     idex_wr_en,    !e_frz);
        chk("idex_flush",     idex_flush,    e_tk || e_lu);
        chk("exmem_wr_en",    exmem_wr_en,   !e_frz);
        chk("exmem_flush",    exmem_flush,   e_tk);
        chk("memwb_bubble",   memwb_bubble,  e_frz);
        chk("timeout_err",    mem_timeout_err, m_err);
        chk("stall_cycles",   stall_cycles,  32'(m_stall));
        chk("branch_flushes", branch_flushes, 32'(m_brf));
    end

    // Model state advance on the clock edge
    always @(posedge clk) begin
        if (!rst) begin
            m_waiting = 0;
            m_wcnt    = 0;
            m_err     = 0;
            m_stall   = 0;
            m_brf     = 0;
        end else begin
            if ((e_frz || e_lu) && m_stall < CMAX) m_stall++;
            if (e_tk && m_brf < CMAX) m_brf++;
            if (m_waiting) begin
                if (dmem_ack) begin
                    m_waiting = 0;
                    m_wcnt    = 0;
                end else begin
                    if (m_wcnt < TO) m_wcnt++;
                    if (m_wcnt == TO) m_err = 1;
                end
            end else if ((mem_mem_read || mem_mem_write) && !dmem_ack) begin
                m_waiting = 1;
            end
        end
    end

    task automatic idle();
        id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        ex_mem_read = 0; ex_rf_wr_num = 0;
        mem_branch = 0; mem_is_equal = 0;
        mem_mem_read = 0; mem_mem_write = 0; dmem_ack = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        idle();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        step();
        step();
        #1;
        chk("rst pc_wr_en", pc_wr_en, 1);
        chk("rst dmem_req", dmem_req, 0);
        chk("rst stall", stall_cycles, 0);
        chk("rst err", mem_timeout_err, 0);
        rst = 1'b1;
        step();

        // Load-use on r5 via rs
        ex_mem_read = 1; ex_rf_wr_num = 5; id_rs = 5; id_uses_rs = 1;
        #1;
        chk("lu pc_wr_en", pc_wr_en, 0);
        chk("lu ifid_wr_en", ifid_wr_en, 0);
        chk("lu idex_flush", idex_flush, 1);
        step();
        idle();
        #1;
        chk("lu release", pc_wr_en, 1);
        chk("lu stall", stall_cycles, 1);
        step();

        // Register 0 never hazards
        ex_mem_read = 1; ex_rf_wr_num = 0; id_rs = 0; id_uses_rs = 1;
        #1;
        chk("r0 pc_wr_en", pc_wr_en, 1);
        step();
        chk("r0 stall", stall_cycles, 1);

        // Taken branch over a concurrent load-use
        ex_mem_read = 1; ex_rf_wr_num = 5; id_rs = 5; id_uses_rs = 1;
        mem_branch = 1; mem_is_equal = 1;
        #1;
        chk("br sel", pc_sel_branch, 1);
        chk("br pc_wr_en", pc_wr_en, 1);
        chk("br ifid_flush", ifid_flush, 1);
        chk("br idex_flush", idex_flush, 1);
        chk("br exmem_flush", exmem_flush, 1);
        step();
        idle();
        chk("br count", branch_flushes, 1);
        chk("br stall", stall_cycles, 1);

        // Zero-wait load
        mem_mem_read = 1; dmem_ack = 1;
        #1;
        chk("zw req", dmem_req, 1);
        chk("zw pc_wr_en", pc_wr_en, 1);
        chk("zw bubble", memwb_bubble, 0);
        step();
        idle();
        #1;
        chk("zw run", dmem_req, 0);
        step();

        // Three-cycle memory wait
        rst_pulse();
        mem_mem_read = 1; dmem_ack = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mw bubble", memwb_bubble, 1);
            chk("mw pc_wr_en", pc_wr_en, 0);
            step();
        end
        dmem_ack = 1;
        #1;
        chk("mw release", pc_wr_en, 1);
        step();
        idle();
        #1;
        chk("mw stall", stall_cycles, 3);
        chk("mw err", mem_timeout_err, 0);
        chk("mw run", dmem_req, 0);
        step();

        // Timeout, then reset in the middle of the wait
        rst_pulse();
        mem_mem_write = 1; dmem_ack = 0;
        for (int i = 0; i < 4; i++) step();
        chk("to early", mem_timeout_err, 0);
        step();
        chk("to set", mem_timeout_err, 1);
        for (int i = 0; i < 3; i++) step();
        chk("to sticky", mem_timeout_err, 1);
        chk("to stall on", pc_wr_en, 0);
        rst = 1'b0;
        #1;
        chk("to rst req", dmem_req, 0);
        chk("to rst err", mem_timeout_err, 0);
        chk("to rst stall", stall_cycles, 0);
        chk("to rst pc", pc_wr_en, 1);
        step();
        idle();
        rst = 1'b1;
        step();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst           = ($urandom_range(0, 199) != 0);
            id_rs         = 5'($urandom_range(0, 7));
            id_rt         = 5'($urandom_range(0, 7));
            id_uses_rs    = 1'($urandom);
            id_uses_rt    = 1'($urandom);
            ex_mem_read   = 1'($urandom);
            ex_rf_wr_num  = 5'($urandom_range(0, 7));
            mem_branch    = ($urandom_range(0, 3) == 0);
            mem_is_equal  = 1'($urandom);
            mem_mem_read  = ($urandom_range(0, 5) == 0);
            mem_mem_write = ($urandom_range(0, 7) == 0);
            dmem_ack      = ($urandom_range(0, 4) < 2);
            step();
        end

        rst = 1'b1;
        idle();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
